// File: rtl/motoro3_pwm_gen_multi.sv
// N-channel motor PWM generator: shared period counter, per-channel on-time with remainder carry.
// Define MOTORO3_PWM_DEADTIME_EN to add dead-time insertion between pwm and pwmN.
module motoro3_pwm_gen_multi #(
  parameter int NCH    = 3,
  parameter int CNT_W  = 12,
  parameter int POS_W  = 16,
  parameter int DEAD_T = 8
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     pwmLenWant,
  input  logic [POS_W-1:0]     pwmMinOn,
  input  logic                 frameLast1,
  input  logic                 frameLast2,
  input  logic [NCH*POS_W-1:0] plLen,
  input  logic [NCH-1:0]       gate,
  output logic [NCH*POS_W-1:0] posSumExt,
  output logic [NCH*POS_W-1:0] accWant,
  output logic [NCH*POS_W-1:0] accReal,
  output logic [NCH-1:0]       pwm,
  output logic [NCH-1:0]       pwmN
);
  localparam logic [POS_W-1:0] POS_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reload_dly_q, reload_dly_d;
  logic             reload, period_start;
  logic [POS_W-1:0] len_ext;

  logic [NCH-1:0][POS_W-1:0] remain_q, remain_d, on_cnt_q, on_cnt_d;
  logic [NCH-1:0][POS_W-1:0] acc_w_q, acc_w_d, acc_r_q, acc_r_d;
  logic [NCH-1:0][POS_W-1:0] acc_want_q, acc_want_d, acc_real_q, acc_real_d;
  logic [NCH-1:0][POS_W-1:0] sum, on_val;
  logic [NCH-1:0]            load, raw;

  function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] a,
                                               input logic [POS_W-1:0] b);
    logic [POS_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[POS_W] ? POS_MAX : s[POS_W-1:0];
  endfunction

  always_comb begin
    reload       = frameLast1 | (cnt_q == CNT_W'(1)) | ~enable;
    period_start = reload_dly_q & ~reload;
    reload_dly_d = reload;
    cnt_d        = reload ? pwmLenWant : cnt_q - CNT_W'(1);
    len_ext      = POS_W'(pwmLenWant);
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      raw[i] = (on_cnt_q[i] != '0);
    end
  end

  // frameLast2 overrides the period-start updates of remain/accW, but the pulse still loads
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sum[i]        = sat_add(remain_q[i], plLen[i*POS_W +: POS_W]);
      load[i]       = gate[i] & (sum[i] >= pwmMinOn);
      on_val[i]     = (sum[i] < len_ext) ? sum[i] : len_ext;
      on_cnt_d[i]   = raw[i] ? on_cnt_q[i] - POS_W'(1) : '0;
      remain_d[i]   = remain_q[i];
      acc_w_d[i]    = acc_w_q[i];
      acc_r_d[i]    = pwm[i] ? sat_add(acc_r_q[i], POS_W'(1)) : acc_r_q[i];
      acc_want_d[i] = acc_want_q[i];
      acc_real_d[i] = acc_real_q[i];
      if (period_start) begin
        acc_w_d[i] = sat_add(acc_w_q[i], plLen[i*POS_W +: POS_W]);
        if (load[i]) begin
          on_cnt_d[i] = on_val[i];
          remain_d[i] = sum[i] - on_val[i];
        end else begin
          remain_d[i] = sum[i];
        end
      end
      if (frameLast2) begin
        acc_want_d[i] = acc_w_q[i];
        acc_real_d[i] = acc_r_q[i];
        acc_w_d[i]    = '0;
        acc_r_d[i]    = '0;
        remain_d[i]   = '0;
      end
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q        <= pwmLenWant;
      reload_dly_q <= 1'b1;
      remain_q     <= '0;
      on_cnt_q     <= '0;
      acc_w_q      <= '0;
      acc_r_q      <= '0;
      acc_want_q   <= '0;
      acc_real_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      reload_dly_q <= reload_dly_d;
      remain_q     <= remain_d;
      on_cnt_q     <= on_cnt_d;
      acc_w_q      <= acc_w_d;
      acc_r_q      <= acc_r_d;
      acc_want_q   <= acc_want_d;
      acc_real_q   <= acc_real_d;
    end
  end

  assign posSumExt = sum;
  assign accWant   = acc_want_q;
  assign accReal   = acc_real_q;

`ifdef MOTORO3_PWM_DEADTIME_EN
  localparam int DT_W = (DEAD_T < 1) ? 1 : $clog2(DEAD_T + 1);
  localparam logic [DT_W-1:0] DT_MAX = DT_W'(DEAD_T);

  logic [NCH-1:0][DT_W-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;

  // A side only drives once raw has been stable for DEAD_T cycles, so the two never overlap
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hi_cnt_d[i] = !raw[i] ? '0 : (hi_cnt_q[i] >= DT_MAX) ? DT_MAX : hi_cnt_q[i] + DT_W'(1);
      lo_cnt_d[i] = raw[i] ? '0 : (lo_cnt_q[i] >= DT_MAX) ? DT_MAX : lo_cnt_q[i] + DT_W'(1);
      pwm[i]      = raw[i] & (hi_cnt_q[i] >= DT_MAX);
      pwmN[i]     = ~raw[i] & (lo_cnt_q[i] >= DT_MAX) & enable;
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end
`else
  assign pwm  = raw;
  assign pwmN = '0;
`endif

endmodule
